// File: rtl/pistormx_bus_engine.sv
// pistormx_bus_engine: queued 68000 bus-master cycle engine. Replays Pi-side
// operations on the Amiga bus with DTACK, VPA/VMA and BERR/timeout endings.
module pistormx_bus_engine #(
  parameter int ADDR_W   = 23,
  parameter int DEPTH    = 4,
  parameter int TIMEOUT  = 255,
  parameter int E_PERIOD = 10,
  parameter int E_HIGH   = 4
) (
  input  logic                       M68K_CLK,
  input  logic                       rst_10s,
  input  logic                       op_valid,
  output logic                       op_ready,
  input  logic                       op_rw,
  input  logic                       op_sz,
  input  logic                       op_a0,
  input  logic [ADDR_W-1:0]          op_addr,
  input  logic [15:0]                op_wdata,
  output logic                       rsp_valid,
  output logic [15:0]                rsp_rdata,
  output logic                       rsp_err,
  output logic [$clog2(DEPTH+1)-1:0] q_count,
  output logic                       busy,
  input  logic                       bus_en,
  output logic [ADDR_W-1:0]          a_out,
  output logic                       a_oe,
  input  logic [15:0]                d_in,
  output logic [15:0]                d_out,
  output logic                       d_oe,
  output logic                       as_n,
  output logic                       uds_n,
  output logic                       lds_n,
  output logic                       rw,
  output logic                       vma_n,
  input  logic                       dtack_n,
  input  logic                       vpa_n,
  input  logic                       berr_n,
  input  logic                       e_ext,
  input  logic                       e_in,
  output logic                       e_out
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int ENT_W = ADDR_W + 19;
  localparam int TO_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam int E_W   = (E_PERIOD > 1) ? $clog2(E_PERIOD) : 1;
  localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(TIMEOUT);
  localparam logic [E_W-1:0]  E_LAST   = E_W'(E_PERIOD - 1);
  localparam logic [E_W-1:0]  E_RISE   = E_W'(E_PERIOD - E_HIGH);

  typedef enum logic [2:0] {IDLE, S01, S23, SW, S56, S7} state_t;

  state_t state, state_next;

  logic [ENT_W-1:0] fifo_mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;
  logic [ENT_W-1:0] head;
  logic             push, launch;

  logic              cur_rw, cur_sz, cur_a0, cur_err;
  logic [ADDR_W-1:0] cur_addr;
  logic [15:0]       cur_wdata;

  logic [TO_W-1:0] to_cnt;
  logic            timed_out;
  logic            vma, vma_done;
  logic [E_W-1:0]  e_cnt;
  logic            e_in_q, e_in_q2;
  logic            ds_on, term, term_err;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // op_ready comes from the registered count, so a same-clock pop never frees
  // a slot early. A launch from S7 keeps back-to-back cycles at 5 clocks.
  assign op_ready  = (count != CNT_W'(DEPTH));
  assign push      = op_valid & op_ready;
  assign launch    = ((state == IDLE) || (state == S7)) && (count != '0) && bus_en;
  assign head      = fifo_mem[rd_ptr];
  assign q_count   = count;
  assign busy      = (state != IDLE) || (count != '0);
  assign timed_out = (TIMEOUT != 0) && (to_cnt == TO_LIMIT);
  assign vma_done  = vma && (e_cnt == E_LAST);
  assign vma_n     = ~vma;
  assign e_out     = (e_cnt >= E_RISE);
  assign a_out     = cur_addr;
  assign d_out     = cur_wdata;
  assign uds_n     = ~(ds_on & (~cur_sz | ~cur_a0));
  assign lds_n     = ~(ds_on & (~cur_sz | cur_a0));

  // Queue storage; contents need no reset because count gates every read.
  always_ff @(posedge M68K_CLK) begin
    if (push) fifo_mem[wr_ptr] <= {op_rw, op_sz, op_a0, op_addr, op_wdata};
  end

  // Queue pointers and occupancy.
  always_ff @(posedge M68K_CLK or posedge rst_10s) begin
    if (rst_10s) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)   wr_ptr <= ptr_inc(wr_ptr);
      if (launch) rd_ptr <= ptr_inc(rd_ptr);
      case ({push, launch})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Bus cycle state register.
  always_ff @(posedge M68K_CLK or posedge rst_10s) begin
    if (rst_10s) state <= IDLE;
    else         state <= state_next;
  end

  // Next state and strobe decode; strobes follow the state register directly.
  always_comb begin
    state_next = state;
    term       = 1'b0;
    term_err   = 1'b0;
    as_n       = 1'b1;
    ds_on      = 1'b0;
    d_oe       = 1'b0;
    a_oe       = 1'b0;
    rw         = 1'b1;
    case (state)
      IDLE: if (launch) state_next = S01;
      S01: begin
        a_oe       = 1'b1;
        rw         = cur_rw;
        state_next = S23;
      end
      S23: begin
        a_oe       = 1'b1;
        rw         = cur_rw;
        as_n       = 1'b0;
        ds_on      = cur_rw;
        d_oe       = ~cur_rw;
        state_next = SW;
      end
      SW: begin
        a_oe  = 1'b1;
        rw    = cur_rw;
        as_n  = 1'b0;
        ds_on = 1'b1;
        d_oe  = ~cur_rw;
        if (!berr_n) begin
          term     = 1'b1;
          term_err = 1'b1;
        end else if (timed_out) begin
          term     = 1'b1;
          term_err = 1'b1;
        end else if (!dtack_n || vma_done) begin
          term = 1'b1;
        end
        if (term) state_next = S56;
      end
      S56: begin
        a_oe       = 1'b1;
        rw         = cur_rw;
        as_n       = 1'b0;
        ds_on      = 1'b1;
        d_oe       = ~cur_rw;
        state_next = S7;
      end
      S7: begin
        a_oe       = 1'b1;
        rw         = cur_rw;
        state_next = launch ? S01 : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Current operation, termination status, VMA, timeout and response registers.
  always_ff @(posedge M68K_CLK or posedge rst_10s) begin
    if (rst_10s) begin
      cur_rw    <= 1'b1;
      cur_sz    <= 1'b0;
      cur_a0    <= 1'b0;
      cur_addr  <= '0;
      cur_wdata <= '0;
      cur_err   <= 1'b0;
      to_cnt    <= '0;
      vma       <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      if (launch) begin
        {cur_rw, cur_sz, cur_a0, cur_addr, cur_wdata} <= head;
        cur_err <= 1'b0;
      end
      if (state == SW && term) cur_err <= term_err;
      if (state == S01)
        to_cnt <= '0;
      else if (state == SW && to_cnt != TO_LIMIT)
        to_cnt <= to_cnt + TO_W'(1);
      if (state == S56)
        vma <= 1'b0;
      else if (state == SW && !vpa_n && e_cnt == E_W'(2))
        vma <= 1'b1;
      if (state == S56) begin
        rsp_err   <= cur_err;
        rsp_rdata <= cur_err ? 16'hFFFF : (cur_rw ? d_in : 16'h0000);
      end
      rsp_valid <= (state == S7);
    end
  end

  // E clock phase counter, resynchronised to a falling external E when tracking.
  always_ff @(posedge M68K_CLK or posedge rst_10s) begin
    if (rst_10s) begin
      e_cnt   <= '0;
      e_in_q  <= 1'b0;
      e_in_q2 <= 1'b0;
    end else begin
      e_in_q  <= e_in;
      e_in_q2 <= e_in_q;
      if (e_ext && e_in_q2 && !e_in_q) e_cnt <= E_W'(1);
      else if (e_cnt == E_LAST)        e_cnt <= '0;
      else                             e_cnt <= e_cnt + E_W'(1);
    end
  end

endmodule

// File: tb/tb_pistormx_bus_engine.sv
// tb_pistormx_bus_engine: table-driven single-cycle vectors plus hand-written
// queue, VPA, timeout and mid-cycle reset sequences.
module tb_pistormx_bus_engine;

  localparam int ADDR_W   = 23;
  localparam int DEPTH    = 4;
  localparam int TIMEOUT  = 255;
  localparam int E_PERIOD = 10;
  localparam int E_HIGH   = 4;

  logic              M68K_CLK = 1'b0;
  logic              rst_10s  = 1'b1;
  logic              op_valid = 1'b0, op_ready;
  logic              op_rw = 1'b1, op_sz = 1'b0, op_a0 = 1'b0;
  logic [ADDR_W-1:0] op_addr = '0;
  logic [15:0]       op_wdata = '0;
  logic              rsp_valid, rsp_err;
  logic [15:0]       rsp_rdata;
  logic [2:0]        q_count;
  logic              busy;
  logic              bus_en = 1'b0;
  logic [ADDR_W-1:0] a_out;
  logic              a_oe;
  logic [15:0]       d_in = '0, d_out;
  logic              d_oe, as_n, uds_n, lds_n, rw, vma_n;
  logic              dtack_n = 1'b1, vpa_n = 1'b1, berr_n = 1'b1;
  logic              e_ext = 1'b0, e_in = 1'b0, e_out;

  int checks   = 0;
  int failures = 0;
  int tb_ecnt;

  typedef struct {
    logic        rw;
    logic        sz;
    logic        a0;
    logic [22:0] addr;
    logic [15:0] wdata;
    logic [15:0] din;
    int          waits;
    logic        use_berr;
    logic [15:0] exp_rdata;
    logic        exp_err;
    logic        exp_uds;
    logic        exp_lds;
    int          exp_lat;
  } vec_t;

  vec_t vecs[6];

  pistormx_bus_engine #(
    .ADDR_W(ADDR_W), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT),
    .E_PERIOD(E_PERIOD), .E_HIGH(E_HIGH)
  ) dut (
    .M68K_CLK(M68K_CLK), .rst_10s(rst_10s),
    .op_valid(op_valid), .op_ready(op_ready), .op_rw(op_rw), .op_sz(op_sz),
    .op_a0(op_a0), .op_addr(op_addr), .op_wdata(op_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .q_count(q_count), .busy(busy), .bus_en(bus_en),
    .a_out(a_out), .a_oe(a_oe), .d_in(d_in), .d_out(d_out), .d_oe(d_oe),
    .as_n(as_n), .uds_n(uds_n), .lds_n(lds_n), .rw(rw), .vma_n(vma_n),
    .dtack_n(dtack_n), .vpa_n(vpa_n), .berr_n(berr_n),
    .e_ext(e_ext), .e_in(e_in), .e_out(e_out)
  );

  // 100 MHz bench clock.
  always #5 M68K_CLK = ~M68K_CLK;

  // Reference E phase: free-running 0..E_PERIOD-1 from reset (E generated internally).
  always @(posedge M68K_CLK or posedge rst_10s) begin
    if (rst_10s) tb_ecnt <= 0;
    else         tb_ecnt <= (tb_ecnt == E_PERIOD - 1) ? 0 : tb_ecnt + 1;
  end

  // Hard stop in case a sequence never returns.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog actual=running required=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      failures++;
      $display("[TB] FAIL %s actual=%0d expected=%0d..%0d", name, act, lo, hi);
    end
  endtask

  // Push one operation: called at a negedge, returns at the negedge after the push edge.
  task automatic apply_stimulus(input logic rw_i, input logic sz_i, input logic a0_i,
                                input logic [22:0] addr_i, input logic [15:0] wdata_i);
    op_rw    = rw_i;
    op_sz    = sz_i;
    op_a0    = a0_i;
    op_addr  = addr_i;
    op_wdata = wdata_i;
    op_valid = 1'b1;
    @(negedge M68K_CLK);
    op_valid = 1'b0;
  endtask

  task automatic run_vector(input int idx);
    vec_t v = vecs[idx];
    int   lat = -1, as_cnt = 0, ds_cnt = 0, doe_cnt = 0;
    logic uds_low = 1'b0, lds_low = 1'b0, addr_ok = 1'b1, dout_ok = 1'b1;
    logic [15:0] rdata = 16'h0;
    logic err = 1'b0;
    d_in    = v.din;
    dtack_n = 1'b1;
    berr_n  = 1'b1;
    apply_stimulus(v.rw, v.sz, v.a0, v.addr, v.wdata);
    // c = clocks since the launch edge; terminator driven so the SW edge 2+waits clocks in sees it
    for (int c = 0; c < 40 && lat < 0; c++) begin
      @(negedge M68K_CLK);
      if (!as_n) as_cnt++;
      if (!uds_n || !lds_n) ds_cnt++;
      if (!uds_n) uds_low = 1'b1;
      if (!lds_n) lds_low = 1'b1;
      if (d_oe) begin
        doe_cnt++;
        if (d_out !== v.wdata) dout_ok = 1'b0;
      end
      if (a_oe && (a_out !== v.addr || rw !== v.rw)) addr_ok = 1'b0;
      if (rsp_valid) begin
        lat   = c;
        rdata = rsp_rdata;
        err   = rsp_err;
      end
      if (c >= 2 + v.waits) begin
        if (v.use_berr) berr_n = 1'b0;
        else            dtack_n = 1'b0;
      end
    end
    dtack_n = 1'b1;
    berr_n  = 1'b1;
    check_output($sformatf("v%0d_latency", idx), lat, v.exp_lat);
    check_output($sformatf("v%0d_err", idx), err, v.exp_err);
    if (v.rw) check_output($sformatf("v%0d_rdata", idx), rdata, v.exp_rdata);
    check_output($sformatf("v%0d_as_low_clks", idx), as_cnt, 3 + v.waits);
    check_output($sformatf("v%0d_ds_low_clks", idx), ds_cnt, v.rw ? 3 + v.waits : 2 + v.waits);
    check_output($sformatf("v%0d_uds_low", idx), uds_low, v.exp_uds);
    check_output($sformatf("v%0d_lds_low", idx), lds_low, v.exp_lds);
    check_output($sformatf("v%0d_doe_clks", idx), doe_cnt, v.rw ? 0 : 3 + v.waits);
    check_output($sformatf("v%0d_addr_rw", idx), addr_ok, 1);
    if (!v.rw) check_output($sformatf("v%0d_dout", idx), dout_ok, 1);
    repeat (2) @(negedge M68K_CLK);
  endtask

  initial begin
    int rsp_at[$];
    logic [15:0] wr_seen[$];
    logic prev_doe;
    int lat;
    logic vma_seen, s7_seen, as_was_low;
    int vma_ecnt, s7_ecnt, e_high, e_bad, rsp_cnt;
    logic s7_vma;
    logic [15:0] rdata;
    logic err;

    //  rw   sz   a0   addr         wdata    din      w  berr exp_rdata exp_err uds  lds  lat
    vecs[0] = '{1'b1, 1'b0, 1'b1, 23'h5FF000, 16'h0000, 16'h1234, 0, 1'b0, 16'h1234, 1'b0, 1'b1, 1'b1, 5};
    vecs[1] = '{1'b0, 1'b1, 1'b1, 23'h000100, 16'h00AB, 16'h0000, 2, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 7};
    vecs[2] = '{1'b1, 1'b1, 1'b0, 23'h012345, 16'h0000, 16'h5A5A, 1, 1'b0, 16'h5A5A, 1'b0, 1'b1, 1'b0, 6};
    vecs[3] = '{1'b0, 1'b0, 1'b0, 23'h7FFFFF, 16'hBEEF, 16'h0000, 0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 5};
    vecs[4] = '{1'b1, 1'b0, 1'b0, 23'h040000, 16'h0000, 16'h9999, 0, 1'b1, 16'hFFFF, 1'b1, 1'b1, 1'b1, 5};
    vecs[5] = '{1'b1, 1'b1, 1'b1, 23'h000001, 16'h0000, 16'h7777, 3, 1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b1, 8};

    // Reset state
    repeat (2) @(negedge M68K_CLK);
    check_output("rst_as_n", as_n, 1);
    check_output("rst_strobes", {uds_n, lds_n, rw, vma_n}, 4'hF);
    check_output("rst_oe", {a_oe, d_oe}, 0);
    check_output("rst_op_ready", op_ready, 1);
    check_output("rst_q_count", q_count, 0);
    check_output("rst_busy", busy, 0);
    check_output("rst_rsp", {rsp_valid, rsp_err}, 0);
    check_output("rst_rdata", rsp_rdata, 0);
    check_output("rst_e_out", e_out, 0);
    rst_10s = 1'b0;
    @(negedge M68K_CLK);

    // Single-operation vectors
    bus_en = 1'b1;
    for (int i = 0; i < 6; i++) run_vector(i);

    // Queue fill with bus_en low, then drain back-to-back
    bus_en   = 1'b0;
    dtack_n  = 1'b0;
    op_valid = 1'b1;
    for (int i = 0; i <= DEPTH; i++) begin
      op_rw    = 1'b0;
      op_sz    = 1'b0;
      op_a0    = 1'b0;
      op_addr  = 23'h000200 + 23'(i);
      op_wdata = 16'h1000 + 16'(i);
      @(negedge M68K_CLK);
      check_output($sformatf("fill%0d_q_count", i), q_count, (i + 1 < DEPTH) ? i + 1 : DEPTH);
      check_output($sformatf("fill%0d_op_ready", i), op_ready, (i + 1 < DEPTH) ? 1 : 0);
    end
    op_valid = 1'b0;
    bus_en   = 1'b1;
    prev_doe = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge M68K_CLK);
      if (rsp_valid) rsp_at.push_back(c);
      if (d_oe && !prev_doe) wr_seen.push_back(d_out);
      prev_doe = d_oe;
    end
    dtack_n = 1'b1;
    check_output("drain_rsp_count", rsp_at.size(), DEPTH);
    check_output("drain_write_count", wr_seen.size(), DEPTH);
    if (rsp_at.size() == DEPTH && wr_seen.size() == DEPTH) begin
      check_output("drain_first_rsp", rsp_at[0], 5);
      for (int k = 1; k < DEPTH; k++)
        check_output($sformatf("drain_spacing%0d", k), rsp_at[k] - rsp_at[k-1], 5);
      for (int k = 0; k < DEPTH; k++)
        check_output($sformatf("drain_order%0d", k), wr_seen[k], 16'h1000 + 16'(k));
    end
    check_output("drain_q_count", q_count, 0);
    check_output("drain_busy", busy, 0);

    // VPA read with generated E
    vpa_n      = 1'b0;
    d_in       = 16'hC0DE;
    vma_seen   = 1'b0;
    s7_seen    = 1'b0;
    as_was_low = 1'b0;
    vma_ecnt   = -1;
    s7_ecnt    = -1;
    s7_vma     = 1'b0;
    e_high     = 0;
    e_bad      = 0;
    rsp_cnt    = 0;
    rdata      = 16'h0;
    err        = 1'b1;
    apply_stimulus(1'b1, 1'b0, 1'b0, 23'h3FF800, 16'h0000);
    for (int c = 0; c < 60 && rsp_cnt == 0; c++) begin
      @(negedge M68K_CLK);
      if (c < E_PERIOD && e_out) e_high++;
      if (e_out !== (tb_ecnt >= E_PERIOD - E_HIGH)) e_bad++;
      // vma is set on the edge that sees e_cnt==2, so e_cnt reads 3 right after
      if (!vma_n && !vma_seen) begin
        vma_seen = 1'b1;
        vma_ecnt = tb_ecnt;
      end
      // S56 is entered on the e_cnt==9 edge, so S7 (as_n released) shows e_cnt==1
      if (as_was_low && as_n && !s7_seen) begin
        s7_seen = 1'b1;
        s7_ecnt = tb_ecnt;
        s7_vma  = vma_n;
      end
      if (!as_n) as_was_low = 1'b1;
      if (rsp_valid) begin
        rsp_cnt++;
        rdata = rsp_rdata;
        err   = rsp_err;
      end
    end
    vpa_n = 1'b1;
    check_output("vpa_vma_ecnt", vma_ecnt, 3);
    check_output("vpa_s7_ecnt", s7_ecnt, 1);
    check_output("vpa_s7_vma_n", s7_vma, 1);
    check_output("vpa_rsp", rsp_cnt, 1);
    check_output("vpa_rdata", rdata, 16'hC0DE);
    check_output("vpa_err", err, 0);
    check_output("e_high_clks", e_high, E_HIGH);
    check_output("e_out_phase_errs", e_bad, 0);
    repeat (2) @(negedge M68K_CLK);

    // DTACK never arrives: forced termination by timeout
    lat = -1;
    d_in = 16'h4321;
    apply_stimulus(1'b1, 1'b0, 1'b0, 23'h001000, 16'h0000);
    for (int c = 0; c < 400 && lat < 0; c++) begin
      @(negedge M68K_CLK);
      if (rsp_valid) begin
        lat   = c;
        rdata = rsp_rdata;
        err   = rsp_err;
      end
    end
    check_range("timeout_latency", lat, TIMEOUT + 3, TIMEOUT + 7);
    check_output("timeout_err", err, 1);
    check_output("timeout_rdata", rdata, 16'hFFFF);
    repeat (2) @(negedge M68K_CLK);

    // Reset pulse in SW with three ops still queued
    for (int i = 0; i < 4; i++)
      apply_stimulus(1'b1, 1'b0, 1'b0, 23'h002000 + 23'(i), 16'h0000);
    check_output("mid_q_count_before", q_count, 3);
    repeat (2) @(negedge M68K_CLK);
    check_output("mid_as_n_before", as_n, 0);
    #2 rst_10s = 1'b1;
    #1;
    check_output("mid_rst_as_n", as_n, 1);
    check_output("mid_rst_a_oe", a_oe, 0);
    check_output("mid_rst_ds", {uds_n, lds_n}, 2'b11);
    check_output("mid_rst_q_count", q_count, 0);
    check_output("mid_rst_busy", busy, 0);
    @(negedge M68K_CLK);
    rst_10s = 1'b0;
    rsp_cnt = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge M68K_CLK);
      if (rsp_valid) rsp_cnt++;
    end
    check_output("mid_rst_no_rsp", rsp_cnt, 0);
    check_output("mid_rst_idle", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
